ysyx_24100012_partial_store: RTL and testbench
==============================================

# ysyx_24100012_partial_store

Store-path counterpart of the partial load unit. It accepts one store request at a time (sb/sh/sw selected by func3), converts it into word-aligned memory write beats with byte strobes and lane-shifted data, and drives them onto the data-memory write port with a valid/ready handshake. A misaligned sh/sw that crosses a word boundary is split into two beats. After the last beat is accepted, the unit pulses a completion response back to the core's memory stage.

## Interface
- ADDR_WIDTH, 32, byte-address width of request and memory ports.
- DATA_WIDTH, 32, data width. Only 32 is supported; there are 4 byte lanes.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- func3  input  3  store width: 000 sb, 001 sh, 010 sw; any other value is illegal.
- req_addr  input  ADDR_WIDTH  byte address.
- req_data  input  DATA_WIDTH  store data, LSB-justified.
- mem_wvalid  output  1  write beat valid.
- mem_wready  input  1  memory accepts the beat.
- mem_waddr  output  ADDR_WIDTH  word-aligned address; bits [1:0] are always 00.
- mem_wdata  output  DATA_WIDTH  lane-shifted write data.
- mem_wmask  output  4  byte strobe; bit i enables byte lane i.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  qualifies resp_valid; set when func3 is illegal.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch func3, address and data.
  - Legal func3 → BEAT0.
  - Illegal func3 → RESP with the error flag set; no memory beat is issued.
- Definitions:
  - len = 1, 2 or 4 bytes.
  - lm = (1<<len)-1, computed 8 bits wide.
  - off = addr[1:0].
  - m8 = lm<<off.
  - base = {addr[AW-1:2],2'b00}.
- BEAT0: mem_waddr=base, mem_wmask=m8[3:0], mem_wdata=data<<(8*off).
  - On handshake, go to BEAT1 if m8[7:4]!=0, else go to RESP.
- BEAT1: mem_waddr=base+4, wrapping modulo 2^ADDR_WIDTH. mem_wmask=m8[7:4], mem_wdata=data>>(8*(4-off)).
  - On handshake → RESP.
- RESP: resp_valid=1 and resp_err=flag for exactly one cycle, then → IDLE.
- Bytes outside the mask in mem_wdata are don't-care. The bench checks only masked lanes.
- Unused high bits of req_data are ignored: bits above 8 for sb, above 16 for sh.

## Timing
- All outputs are registered. Reset values:
  - req_ready=0 while rst is high, 1 in IDLE after release.
  - mem_wvalid=0, mem_waddr=0, mem_wdata=0, mem_wmask=0.
  - resp_valid=0, resp_err=0.
  - State = IDLE.
- Let acceptance occur at edge T.
  - mem_wvalid rises in cycle T+1.
  - Beat 0 completes at the first edge where mem_wvalid&&mem_wready.
  - For a split store, beat 1 is presented in the following cycle. There is no idle gap and no bubble is allowed.
  - resp_valid is high in the cycle after the final handshake. req_ready returns the cycle after that.
- Minimum latency with mem_wready tied high:
  - Single-beat store: 3 cycles from accept to resp_valid.
  - Split store: 4 cycles.
  - Illegal func3: resp_valid in T+1.
- Once mem_wvalid is asserted, it must not drop, and mem_waddr, mem_wdata and mem_wmask must not change, until the handshake completes. This holds for any number of mem_wready=0 stall cycles.
- req_ready=0 in BEAT0, BEAT1 and RESP. A req_valid arriving during those states is ignored and not latched.
- mem_wready high while mem_wvalid=0 has no effect.
- Reset mid-operation: all outputs clear immediately (asynchronously). The in-flight store is dropped without a response, and any beat already completed is not undone.

## Test plan
- sb, addr 0x80000003, data 0x12345678, wready=1 → one beat: addr 0x80000000, mask 1000, lane3=0x78. resp_valid at T+3, resp_err=0.
- sh, addr 0x80000002, data 0x0000ABCD → one beat: addr 0x80000000, mask 1100, wdata[31:16]=0xABCD.
- sw, addr 0x80000001, data 0xDDCCBBAA → two beats, then resp at T+4:
  - Beat 0: addr 0x80000000, mask 1110, wdata[31:8]=0xCCBBAA.
  - Beat 1: addr 0x80000004, mask 0001, wdata[7:0]=0xDD.
- sw, addr 0xFFFFFFFE, data 0x11223344, with wready low for 5 cycles on each beat:
  - Outputs stay stable throughout each stall.
  - Beat 1 addr is 0x00000000 with mask 0011.
  - req_ready stays 0 until the cycle after resp_valid.
- func3=100 accepted → resp_valid=1 and resp_err=1 at T+1. mem_wvalid never asserts.
- rst asserted during a stalled beat 1 → mem_wvalid and resp_valid go 0 the same cycle. No response is produced. req_ready=1 in the first cycle after rst is released.

Source files
------------

// File: rtl/ysyx_24100012_partial_store.sv
// ysyx_24100012_partial_store: turns one sb/sh/sw request into one or two word-aligned strobed write beats, then pulses a response
// Ports: clk/rst (async, active-high); req_valid/req_ready/func3/req_addr/req_data request side;
// mem_wvalid/mem_wready/mem_waddr/mem_wdata/mem_wmask write port; resp_valid/resp_err completion.
module ysyx_24100012_partial_store #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wmask,
    output logic                  resp_valid,
    output logic                  resp_err
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    state_t                state;
    logic [2:0]            f3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
    logic [7:0]            lm;
    logic [7:0]            m8;
    logic [4:0]            sh0;
    logic [5:0]            sh1;
    // m8[7:4] holds the lanes that spill into the next word
    always_comb begin
        lm   = f3 == 3'b000 ? 8'h01 : f3 == 3'b001 ? 8'h03 : 8'h0f;
        m8   = lm << addr[1:0];
        base = {addr[ADDR_WIDTH-1:2], 2'b00};
        sh0  = {addr[1:0], 3'b000};
        sh1  = 6'd32 - {1'b0, sh0};
    end
    // Beat 0 and the response are each presented one cycle after their state is entered;
    // beat 1 is loaded on the beat-0 handshake so the two beats run back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            f3         <= '0;
            addr       <= '0;
            data       <= '0;
            err        <= 1'b0;
            mem_wvalid <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        f3        <= func3;
                        addr      <= req_addr;
                        data      <= req_data;
                        err       <= func3 > 3'b010;
                        req_ready <= 1'b0;
                        state     <= func3 > 3'b010 ? RESP : BEAT0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                BEAT0: begin
                    if (!mem_wvalid) begin
                        mem_wvalid <= 1'b1;
                        mem_waddr  <= base;
                        mem_wmask  <= m8[3:0];
                        mem_wdata  <= data << sh0;
                    end else if (mem_wready) begin
                        if (|m8[7:4]) begin
                            state     <= BEAT1;
                            mem_waddr <= base + ADDR_WIDTH'(4);
                            mem_wmask <= m8[7:4];
                            mem_wdata <= data >> sh1;
                        end else begin
                            state      <= RESP;
                            mem_wvalid <= 1'b0;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_wready) begin
                        state      <= RESP;
                        mem_wvalid <= 1'b0;
                    end
                end
                RESP: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                    end else begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_24100012_partial_store.sv
// tb_ysyx_24100012_partial_store: randomized store traffic checked against a byte-level reference model
module tb_ysyx_24100012_partial_store;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  func3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        mem_wvalid;
    logic        mem_wready = 1'b0;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        resp_valid;
    logic        resp_err;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ysyx_24100012_partial_store #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .func3(func3), .req_addr(req_addr), .req_data(req_data),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .resp_valid(resp_valid), .resp_err(resp_err)
    );

    // The model places each stored byte at its own byte address and groups bytes by word.
    task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input int stall, input bit junk);
        logic [31:0] ew[2];
        logic [31:0] ed[2];
        logic [3:0]  em[2];
        logic [31:0] ba;
        logic [31:0] bm;
        int          len, nb, b, stall_left, resp_cyc, last_hs, w, exp_cyc;
        bit          err, pv, pr, exp_v, done;
        len = f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4;
        err = f3 > 3'd2;
        nb  = 0;
        for (int j = 0; j < 2; j++) begin
            ew[j] = '0; ed[j] = '0; em[j] = '0;
        end
        if (!err) begin
            for (int i = 0; i < len; i++) begin
                ba = a + 32'(i);
                if (nb == 0 || {ba[31:2], 2'b00} != ew[nb-1]) begin
                    ew[nb] = {ba[31:2], 2'b00};
                    nb++;
                end
                em[nb-1][ba[1:0]] = 1'b1;
                ed[nb-1][8*ba[1:0] +: 8] = d[8*i +: 8];
            end
        end
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_before_req got %b want 1", req_ready);
        end
        req_valid = 1'b1; func3 = f3; req_addr = a; req_data = d; mem_wready = 1'($urandom);
        @(posedge clk); #1;
        if (junk) begin
            func3 = 3'($urandom); req_addr = $urandom; req_data = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        mem_wready = 1'($urandom);
        pv = mem_wvalid; pr = mem_wready;
        b = 0; stall_left = stall; resp_cyc = -1; last_hs = 0; done = 1'b0;
        for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
            @(posedge clk); #1;
            if (pv && pr) begin
                b++; last_hs = cyc;
            end
            exp_v = !err && b < nb;
            checks++;
            if (mem_wvalid !== exp_v) begin
                errors++; $display("FAIL wvalid cyc %0d got %b want %b", cyc, mem_wvalid, exp_v);
            end
            checks++;
            if (req_ready !== 1'b0) begin
                errors++; $display("FAIL ready_busy cyc %0d got %b want 0", cyc, req_ready);
            end
            if (mem_wvalid && exp_v) begin
                for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{em[b][i]}};
                checks++;
                if (mem_waddr !== ew[b] || mem_wmask !== em[b] || (mem_wdata & bm) !== (ed[b] & bm)) begin
                    errors++;
                    $display("FAIL beat%0d cyc %0d got addr %h mask %b data %h want addr %h mask %b data %h",
                             b, cyc, mem_waddr, mem_wmask, mem_wdata & bm, ew[b], em[b], ed[b] & bm);
                end
            end
            if (resp_valid === 1'b1) begin
                resp_cyc = cyc; done = 1'b1;
                checks++;
                if (resp_err !== err) begin
                    errors++; $display("FAIL resp_err got %b want %b", resp_err, err);
                end
            end
            if (mem_wvalid) begin
                if (stall_left > 0) begin
                    mem_wready = 1'b0; stall_left--;
                end else begin
                    mem_wready = 1'b1; stall_left = stall;
                end
            end else begin
                mem_wready = 1'($urandom);
            end
            pv = mem_wvalid; pr = mem_wready;
        end
        req_valid = 1'b0;
        exp_cyc = err ? 1 : last_hs + 1;
        checks++;
        if (resp_cyc != exp_cyc) begin
            errors++; $display("FAIL resp_cycle got %0d want %0d", resp_cyc, exp_cyc);
        end
        if (stall == 0) begin
            exp_cyc = err ? 1 : nb + 2;
            checks++;
            if (resp_cyc != exp_cyc) begin
                errors++; $display("FAIL min_latency got %0d want %0d", resp_cyc, exp_cyc);
            end
        end
        checks++;
        if (b != nb) begin
            errors++; $display("FAIL beat_count got %0d want %0d", b, nb);
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL after_resp got resp %b ready %b want resp 0 ready 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, mem_wvalid, resp_valid, resp_err} !== 4'b0 || mem_waddr !== '0 || mem_wdata !== '0 || mem_wmask !== '0) begin
            errors++;
            $display("FAIL reset_state got ready %b wv %b rv %b re %b addr %h data %h mask %b want all 0",
                     req_ready, mem_wvalid, resp_valid, resp_err, mem_waddr, mem_wdata, mem_wmask);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_directed;
        run_store(3'b000, 32'h8000_0003, 32'h1234_5678, 0, 1'b0);
        run_store(3'b001, 32'h8000_0002, 32'h0000_ABCD, 0, 1'b0);
        run_store(3'b010, 32'h8000_0001, 32'hDDCC_BBAA, 0, 1'b0);
        run_store(3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 5, 1'b1);
    endtask

    task automatic test_illegal;
        run_store(3'b100, 32'h8000_0000, 32'hCAFE_F00D, 0, 1'b0);
        for (int k = 3; k < 8; k++) run_store(3'(k), $urandom, $urandom, 0, 1'b1);
    endtask

    task automatic test_random;
        logic [2:0] f3;
        for (int n = 0; n < 40; n++) begin
            f3 = ($urandom % 8 < 6) ? 3'($urandom % 3) : 3'(3 + $urandom % 5);
            run_store(f3, $urandom, $urandom, int'($urandom % 4), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid;
        int w;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        req_valid = 1'b1; func3 = 3'b010; req_addr = 32'hFFFF_FFFE; req_data = $urandom; mem_wready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        while (!(mem_wvalid === 1'b1 && mem_waddr === 32'h0) && w < 10) begin
            @(posedge clk); #1; w++;
        end
        mem_wready = 1'b0;
        checks++;
        if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h0 || mem_wmask !== 4'b0011) begin
            errors++; $display("FAIL mid_beat1 got wv %b addr %h mask %b want 1 00000000 0011", mem_wvalid, mem_waddr, mem_wmask);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_wvalid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0 || mem_wmask !== 4'b0) begin
            errors++; $display("FAIL async_clear got wv %b rv %b ready %b mask %b want 0 0 0 0", mem_wvalid, resp_valid, req_ready, mem_wmask);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_wvalid !== 1'b0) begin
            errors++; $display("FAIL post_reset got ready %b rv %b wv %b want 1 0 0", req_ready, resp_valid, mem_wvalid);
        end
        run_store(3'b001, 32'h0000_1003, 32'h0000_BEEF, 1, 1'b0);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_illegal;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
